// File: rtl/hash_ctl_pkg.sv
// Shared types and constants for the hash W-unit sequencer and its round counter.
package hash_ctl_pkg;

    localparam int unsigned RND_256 = 64;
    localparam int unsigned RND_384 = 80;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned WOP_W   = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_KEYI,
        ST_MSG,
        ST_PAD,
        ST_RND,
        ST_KEYO,
        ST_FIN,
        ST_FIN_LD,
        ST_DONE,
        ST_ABRT
    } state_e;

    typedef enum logic [WOP_W-1:0] {
        WOP_MSG   = 2'b00,
        WOP_IKEY  = 2'b01,
        WOP_OKEY  = 2'b10,
        WOP_HASHF = 2'b11
    } wop_e;

    typedef enum logic [2:0] {
        PH_IKEY,
        PH_MSG,
        PH_LAST,
        PH_OKEY,
        PH_FINAL
    } phase_e;

    // Registered strobe bundle driven towards the W unit, host and core
    typedef struct packed {
        wop_e w_op;
        logic w_en;
        logic h_pad;
        logic h_clr;
        logic kw_nxt;
        logic kw_done;
        logic rnd_vld;
        logic blk_done;
        logic job_done;
        logic busy;
        logic msg_rdy;
    } ctl_out_t;

endpackage

// File: rtl/hash_w_rnd_cnt.sv
// Round counter: clear-to-zero, saturating increment, 64/80 terminal-count select.
module hash_w_rnd_cnt
    import hash_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             sel_384,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c,
    output logic             tc_nxt_c
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last;

    assign last = sel_384 ? CNT_W'(RND_384 - 1) : CNT_W'(RND_256 - 1);

    // Never steps past the last round of the block
    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt != last)) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    assign tc_c     = (cnt == last);
    assign tc_nxt_c = (cnt_d == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/hash_w_ctl.sv
// Sequencer for the hash W unit: walks plain or HMAC jobs block by block and
// times the compression rounds. All outputs are flops decoded from next state.
module hash_w_ctl
    import hash_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [OP_W-1:0]  hash_op,
    input  logic             msg_vld,
    input  logic             msg_last,
    output logic             msg_rdy,
    input  logic             h_flg_ovf,
    input  logic             core_rdy,
    output logic [WOP_W-1:0] w_op,
    output logic             w_en,
    output logic             h_pad,
    output logic             h_clr,
    output logic             kw_nxt,
    output logic             kw_done,
    output logic             h_flg_384,
    output logic [CNT_W-1:0] rnd_cnt,
    output logic             rnd_vld,
    output logic             blk_done,
    output logic             job_done,
    output logic             busy
);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic             hmac_q, hmac_d;
    logic             m384_q, m384_d;
    logic             run_q, run_d;
    logic             post_q, post_d;
    logic             cnt_clr, cnt_inc;
    logic             cnt_tc_c, cnt_tc_nxt_c;
    logic [CNT_W-1:0] cnt_q;
    ctl_out_t         out_q, out_d;

    // Low op bits select the digest length inside the W unit, not here
    logic unused_op;
    assign unused_op = ^hash_op[1:0];

    hash_w_rnd_cnt u_rnd_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .sel_384  (m384_q),
        .cnt      (cnt_q),
        .tc_c     (cnt_tc_c),
        .tc_nxt_c (cnt_tc_nxt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_IKEY;
            hmac_q  <= 1'b0;
            m384_q  <= 1'b0;
            run_q   <= 1'b0;
            post_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hmac_q  <= hmac_d;
            m384_q  <= m384_d;
            run_q   <= run_d;
            post_q  <= post_d;
            out_q   <= out_d;
        end
    end

    // Next state; RND has three sub-steps: wait core_rdy, run rounds, post-block decision
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hmac_d  = hmac_q;
        m384_d  = m384_q;
        run_d   = 1'b0;
        post_d  = 1'b0;
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR;
                    hmac_d  = hash_op[3];
                    m384_d  = hash_op[2];
                end
            end
            ST_CLR:  state_d = hmac_q ? ST_KEYI : ST_MSG;
            ST_KEYI: begin
                phase_d = PH_IKEY;
                state_d = ST_RND;
            end
            ST_MSG: begin
                if (msg_vld && out_q.msg_rdy) begin
                    phase_d = msg_last ? PH_LAST : PH_MSG;
                    state_d = msg_last ? ST_PAD : ST_RND;
                end
            end
            ST_PAD:  state_d = ST_RND;
            ST_RND: begin
                if (post_q) begin
                    case (phase_q)
                        PH_IKEY, PH_MSG: state_d = ST_MSG;
                        PH_LAST:  state_d = h_flg_ovf ? ST_PAD : (hmac_q ? ST_KEYO : ST_DONE);
                        PH_OKEY:  state_d = ST_FIN;
                        default:  state_d = h_flg_ovf ? ST_PAD : ST_DONE;
                    endcase
                end else if (run_q) begin
                    if (cnt_tc_c) begin
                        post_d = 1'b1;
                    end else begin
                        run_d   = 1'b1;
                        cnt_clr = 1'b0;
                        cnt_inc = 1'b1;
                    end
                end else begin
                    run_d = core_rdy;
                end
            end
            ST_KEYO: begin
                phase_d = PH_OKEY;
                state_d = ST_RND;
            end
            ST_FIN:    if (core_rdy) state_d = ST_FIN_LD;
            ST_FIN_LD: begin
                phase_d = PH_FINAL;
                state_d = ST_PAD;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_ABRT;
            run_d   = 1'b0;
            post_d  = 1'b0;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    // Output decode of the next state; w_op keeps its last value between loads
    always_comb begin
        out_d      = '0;
        out_d.w_op = out_q.w_op;
        case (state_d)
            ST_CLR, ST_ABRT: out_d.h_clr = 1'b1;
            ST_KEYI: begin
                out_d.w_en = 1'b1;
                out_d.w_op = WOP_IKEY;
            end
            ST_MSG: begin
                out_d.w_en    = 1'b1;
                out_d.msg_rdy = 1'b1;
                out_d.w_op    = WOP_MSG;
            end
            ST_KEYO: begin
                out_d.w_en = 1'b1;
                out_d.w_op = WOP_OKEY;
            end
            ST_FIN_LD: begin
                out_d.w_en = 1'b1;
                out_d.w_op = WOP_HASHF;
            end
            ST_PAD:  out_d.h_pad    = 1'b1;
            ST_DONE: out_d.job_done = 1'b1;
            default: ;
        endcase
        out_d.rnd_vld  = run_d;
        out_d.kw_nxt   = run_d & ~cnt_tc_nxt_c;
        out_d.kw_done  = run_d & cnt_tc_nxt_c;
        out_d.blk_done = run_d & cnt_tc_nxt_c;
        out_d.busy     = (state_d != ST_IDLE);
    end

    assign msg_rdy   = out_q.msg_rdy;
    assign w_op      = out_q.w_op;
    assign w_en      = out_q.w_en;
    assign h_pad     = out_q.h_pad;
    assign h_clr     = out_q.h_clr;
    assign kw_nxt    = out_q.kw_nxt;
    assign kw_done   = out_q.kw_done;
    assign h_flg_384 = m384_q;
    assign rnd_cnt   = cnt_q;
    assign rnd_vld   = out_q.rnd_vld;
    assign blk_done  = out_q.blk_done;
    assign job_done  = out_q.job_done;
    assign busy      = out_q.busy;

endmodule

// File: tb/tb_hash_w_ctl.sv
// Directed bench for hash_w_ctl: plain, overflow-pad, HMAC, stall, abort and reset scenarios.
module tb_hash_w_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, msg_vld = 1'b0, msg_last = 1'b0;
    logic       h_flg_ovf = 1'b0, core_rdy = 1'b0;
    logic [3:0] hash_op = 4'h0;
    logic       msg_rdy, w_en, h_pad, h_clr, kw_nxt, kw_done, h_flg_384;
    logic       rnd_vld, blk_done, job_done, busy;
    logic [1:0] w_op;
    logic [6:0] rnd_cnt;

    int checks = 0;
    int errors = 0;

    int          r_pad, r_blk, r_job, r_vld, r_nxt, r_kwbad, r_kwd_cyc, r_job_cyc, r_wen;
    bit          r_to, r_h384;
    logic [63:0] r_ev;
    logic [15:0] r_ops, r_pad_ops;

    hash_w_ctl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .hash_op   (hash_op),
        .msg_vld   (msg_vld),
        .msg_last  (msg_last),
        .msg_rdy   (msg_rdy),
        .h_flg_ovf (h_flg_ovf),
        .core_rdy  (core_rdy),
        .w_op      (w_op),
        .w_en      (w_en),
        .h_pad     (h_pad),
        .h_clr     (h_clr),
        .kw_nxt    (kw_nxt),
        .kw_done   (kw_done),
        .h_flg_384 (h_flg_384),
        .rnd_cnt   (rnd_cnt),
        .rnd_vld   (rnd_vld),
        .blk_done  (blk_done),
        .job_done  (job_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Runs a whole job with an always-ready host and core; event codes:
    // 1 h_clr, 2 w_en load, 3 h_pad, 4 kw_done, 5 job_done
    task automatic run_job(input logic [3:0] op, input int nblk, input bit ovf_en, input int last_rnd);
        int hs   = 0;
        bit done = 1'b0;
        logic pclr = 1'b0, pen = 1'b0;
        r_pad = 0; r_blk = 0; r_job = 0; r_vld = 0; r_nxt = 0; r_kwbad = 0;
        r_kwd_cyc = 0; r_job_cyc = 0; r_wen = 0; r_h384 = 1'b0;
        r_ev = '0; r_ops = '0; r_pad_ops = '0;
        hash_op = op; start = 1'b1; core_rdy = 1'b1; msg_vld = 1'b1; msg_last = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (h_clr && !pclr) r_ev = {r_ev[59:0], 4'h1};
            if (w_en && !pen) begin
                r_ev  = {r_ev[59:0], 4'h2};
                r_ops = {r_ops[13:0], w_op};
                r_wen++;
            end
            if (h_pad) begin
                r_ev      = {r_ev[59:0], 4'h3};
                r_pad_ops = {r_pad_ops[13:0], w_op};
                r_pad++;
            end
            if (kw_done) begin
                r_ev      = {r_ev[59:0], 4'h4};
                r_kwd_cyc = c;
                if (rnd_cnt != 7'(last_rnd)) r_kwbad++;
            end
            if (blk_done) r_blk++;
            if (rnd_vld)  r_vld++;
            if (kw_nxt)   r_nxt++;
            if (job_done) begin
                r_ev      = {r_ev[59:0], 4'h5};
                r_job_cyc = c;
                r_job++;
                done      = 1'b1;
            end
            if (busy) r_h384 = h_flg_384;
            pclr      = h_clr;
            pen       = w_en;
            msg_last  = (hs == nblk - 1);
            if (msg_rdy) hs++;
            h_flg_ovf = ovf_en && (r_pad == 1);
            @(negedge clk);
        end
        r_to = !done;
        msg_vld = 1'b0; msg_last = 1'b0; h_flg_ovf = 1'b0; core_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({msg_rdy, w_op, w_en, h_pad, h_clr, kw_nxt, kw_done, h_flg_384, rnd_cnt,
             rnd_vld, blk_done, job_done, busy} !== 20'h0)
            begin errors++; $display("FAIL reset_outputs got busy=%b w_op=%b h_clr=%b exp all 0", busy, w_op, h_clr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_plain_256();
        run_job(4'b0000, 1, 1'b0, 63);
        checks++;
        if (r_to) begin errors++; $display("FAIL t1_timeout got no job_done exp job_done"); end
        checks++;
        if (r_ev !== 64'h12345) begin errors++; $display("FAIL t1_events got %0h exp 12345", r_ev); end
        checks++;
        if (r_vld != 64 || r_nxt != 63) begin errors++; $display("FAIL t1_rounds got vld=%0d nxt=%0d exp 64 63", r_vld, r_nxt); end
        checks++;
        if (r_kwbad != 0) begin errors++; $display("FAIL t1_kw_done_cnt got %0d bad exp 0", r_kwbad); end
        checks++;
        if (r_job_cyc - r_kwd_cyc != 2) begin errors++; $display("FAIL t1_job_latency got %0d exp 2", r_job_cyc - r_kwd_cyc); end
        checks++;
        if (r_blk != 1 || r_job != 1 || r_h384 !== 1'b0) begin errors++; $display("FAIL t1_counts got blk=%0d job=%0d h384=%b exp 1 1 0", r_blk, r_job, r_h384); end
    endtask

    task automatic test_sha384_ovf();
        run_job(4'b0100, 1, 1'b1, 79);
        checks++;
        if (r_ev !== 64'h1234345) begin errors++; $display("FAIL t2_events got %0h exp 1234345", r_ev); end
        checks++;
        if (r_pad != 2 || r_blk != 2 || r_vld != 160) begin errors++; $display("FAIL t2_counts got pad=%0d blk=%0d vld=%0d exp 2 2 160", r_pad, r_blk, r_vld); end
        checks++;
        if (r_kwbad != 0 || r_h384 !== 1'b1) begin errors++; $display("FAIL t2_kw_done_cnt got bad=%0d h384=%b exp 0 1", r_kwbad, r_h384); end
    endtask

    task automatic test_hmac_256();
        run_job(4'b1000, 2, 1'b0, 63);
        checks++;
        if (r_ev !== 64'h12424234242345) begin errors++; $display("FAIL t3_events got %0h exp 12424234242345", r_ev); end
        checks++;
        if (r_ops !== 16'h010B || r_wen != 5) begin errors++; $display("FAIL t3_wop_seq got %0h n=%0d exp 10b 5", r_ops, r_wen); end
        checks++;
        if (r_pad_ops !== 16'h0003 || r_pad != 2) begin errors++; $display("FAIL t3_pad_ops got %0h n=%0d exp 3 2", r_pad_ops, r_pad); end
        checks++;
        if (r_blk != 5 || r_job != 1 || r_vld != 320) begin errors++; $display("FAIL t3_counts got blk=%0d job=%0d vld=%0d exp 5 1 320", r_blk, r_job, r_vld); end
    endtask

    task automatic test_stall();
        int  bad_vld = 0, bad_rdy = 0;
        bit  seen = 1'b0;
        hash_op = 4'b0000; msg_vld = 1'b1; msg_last = 1'b0; core_rdy = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (msg_rdy !== 1'b1 || w_en !== 1'b1) begin errors++; $display("FAIL t4_msg_rdy got rdy=%b en=%b exp 1 1", msg_rdy, w_en); end
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (rnd_vld !== 1'b0 || rnd_cnt !== 7'd0) bad_vld++;
            if (msg_rdy !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        checks++;
        if (bad_vld != 0) begin errors++; $display("FAIL t4_stall_rnd got %0d bad cycles exp 0", bad_vld); end
        core_rdy = 1'b1;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (msg_rdy !== 1'b0) bad_rdy++;
            if (kw_done) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || bad_rdy != 0) begin errors++; $display("FAIL t4_rdy_hold got seen=%b bad=%0d exp 1 0", seen, bad_rdy); end
        @(negedge clk);
        checks++;
        if (msg_rdy !== 1'b0) begin errors++; $display("FAIL t4_post got msg_rdy=%b exp 0", msg_rdy); end
        @(negedge clk);
        checks++;
        if (msg_rdy !== 1'b1) begin errors++; $display("FAIL t4_next_blk got msg_rdy=%b exp 1", msg_rdy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; msg_vld = 1'b0; core_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit hit = 1'b0;
        int jd = 0;
        hash_op = 4'b0000; msg_vld = 1'b1; msg_last = 1'b1; core_rdy = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (rnd_vld && rnd_cnt == 7'd30) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL t5_reach_r30 got rnd_cnt=%0d exp 30", rnd_cnt); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; msg_vld = 1'b0; msg_last = 1'b0;
        checks++;
        if ({h_clr, busy, w_en, h_pad, kw_nxt, kw_done, blk_done, msg_rdy, rnd_vld, job_done} !== 10'b1100000000)
            begin errors++; $display("FAIL t5_abort_clr got clr=%b busy=%b nxt=%b vld=%b exp clr busy only", h_clr, busy, kw_nxt, rnd_vld); end
        @(negedge clk);
        checks++;
        if ({busy, h_clr, job_done} !== 3'b000) begin errors++; $display("FAIL t5_idle got busy=%b clr=%b jd=%b exp 000", busy, h_clr, job_done); end
        for (int i = 0; i < 5; i++) begin
            if (job_done) jd++;
            @(negedge clk);
        end
        checks++;
        if (jd != 0) begin errors++; $display("FAIL t5_no_job_done got %0d exp 0", jd); end
        core_rdy = 1'b0;
    endtask

    task automatic test_start_abort_reset();
        bit hit = 1'b0;
        hash_op = 4'b0000; msg_vld = 1'b1; msg_last = 1'b1; core_rdy = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (rnd_vld && rnd_cnt == 7'd5) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL t6_reach_r5 got rnd_cnt=%0d exp 5", rnd_cnt); end
        msg_vld = 1'b0; start = 1'b1;
        @(negedge clk);
        checks++;
        if (rnd_cnt !== 7'd6 || h_clr !== 1'b0) begin errors++; $display("FAIL t6_start_busy got cnt=%0d clr=%b exp 6 0", rnd_cnt, h_clr); end
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({h_clr, rnd_vld, w_en} !== 3'b100) begin errors++; $display("FAIL t6_abort_wins got clr=%b vld=%b en=%b exp 100", h_clr, rnd_vld, w_en); end
        @(negedge clk);
        checks++;
        if ({busy, h_clr} !== 2'b00) begin errors++; $display("FAIL t6_idle got busy=%b clr=%b exp 00", busy, h_clr); end
        @(negedge clk);
        checks++;
        if ({busy, h_clr, w_en} !== 3'b000) begin errors++; $display("FAIL t6_no_restart got busy=%b clr=%b en=%b exp 000", busy, h_clr, w_en); end
        hash_op = 4'b0100; msg_vld = 1'b1; msg_last = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (rnd_vld && rnd_cnt == 7'd10) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit || h_flg_384 !== 1'b1) begin errors++; $display("FAIL t6_reach_r10 got cnt=%0d h384=%b exp 10 1", rnd_cnt, h_flg_384); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({msg_rdy, w_op, w_en, h_pad, h_clr, kw_nxt, kw_done, h_flg_384, rnd_cnt,
             rnd_vld, blk_done, job_done, busy} !== 20'h0)
            begin errors++; $display("FAIL t6_async_rst got cnt=%0d vld=%b busy=%b h384=%b exp all 0", rnd_cnt, rnd_vld, busy, h_flg_384); end
        msg_vld = 1'b0; msg_last = 1'b0; core_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_plain_256();
        test_sha384_ovf();
        test_hmac_256();
        test_stall();
        test_abort();
        test_start_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
